// File: rtl/pc_unit_pkg.sv
// Shared fetch-stage definitions: boot/exception vectors, PC FSM states and
// the exception-bundle record the fetch stage contributes to.
package pc_unit_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [PC_W-1:0] EXC_VECTOR   = 32'hBFC0_0380;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_PEND = 1'b1
  } pc_state_t;

  // Fetch-stage slice of the pipeline exception bundle.
  typedef struct packed {
    logic            addr_err;
    logic [PC_W-1:0] bad_vaddr;
  } if_exc_t;

endpackage

// File: rtl/pc_unit_npc_sel.sv
// Next-PC priority mux: exception > eret > pending branch > ID branch > PC+4.
module npc_sel
  import pc_unit_pkg::*;
(
  input  logic            except_req,
  input  logic            eret_req,
  input  logic [PC_W-1:0] epc,
  input  logic            pend,
  input  logic [PC_W-1:0] pend_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] npc
);

  always_comb begin
    npc = pc + 32'd4;
    if (except_req)        npc = EXC_VECTOR;
    else if (eret_req)     npc = epc;
    else if (pend)         npc = pend_target;
    else if (branch_taken) npc = branch_target;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with a one-entry pending-branch FSM for stalled fetch.
// Build macro IF_ADDR_ERR_EN enables the misaligned fetch-address flag.
module pc_unit
  import pc_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            IF_PCWr,
  input  logic            ID_BranchTaken,
  input  logic [PC_W-1:0] ID_BranchTarget,
  input  logic            MEM_ExceptReq,
  input  logic            MEM_EretReq,
  input  logic [PC_W-1:0] CP0_EPC,
  output logic [PC_W-1:0] IF_PC,
  output logic [PC_W-1:0] IF_NPC,
  output logic            IF_WrongAddressinIF,
  output logic            IF_BranchPend
);

  pc_state_t       state, next_state;
  logic [PC_W-1:0] pend_target;
  logic            redirect;
  logic            capture;
  logic            pc_en;

  assign redirect = MEM_ExceptReq | MEM_EretReq;
  assign pc_en    = IF_PCWr | redirect;
  // A branch resolved while fetch is stalled must be remembered until fetch resumes.
  assign capture  = (state == PC_RUN) & ID_BranchTaken & ~IF_PCWr & ~redirect;

  npc_sel u_npc_sel (
    .except_req    (MEM_ExceptReq),
    .eret_req      (MEM_EretReq),
    .epc           (CP0_EPC),
    .pend          (state == PC_PEND),
    .pend_target   (pend_target),
    .branch_taken  (ID_BranchTaken),
    .branch_target (ID_BranchTarget),
    .pc            (IF_PC),
    .npc           (IF_NPC)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= PC_RUN;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (redirect) begin
      next_state = PC_RUN;
    end else begin
      case (state)
        PC_RUN:  if (ID_BranchTaken && !IF_PCWr) next_state = PC_PEND;
        PC_PEND: if (IF_PCWr)                    next_state = PC_RUN;
        default: next_state = PC_RUN;
      endcase
    end
  end

  always_comb begin
    IF_BranchPend = (state == PC_PEND);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      IF_PC       <= RESET_VECTOR;
      pend_target <= '0;
    end else begin
      if (pc_en)         IF_PC       <= IF_NPC;
      if (redirect)      pend_target <= '0;
      else if (capture)  pend_target <= ID_BranchTarget;
    end
  end

`ifdef IF_ADDR_ERR_EN
  assign IF_WrongAddressinIF = |IF_PC[1:0];
`else
  assign IF_WrongAddressinIF = 1'b0;
`endif

endmodule
